// File: rtl/axis_pattern_source.sv
// axis_pattern_source
//   AXI-Stream master that emits a deterministic incrementing-byte stream.
//   Word w, lane ii carries (seed + w*BYTES + ii) mod 256, so a receiver can
//   rebuild the data from the seed alone. Run length, packet framing and
//   LFSR-based tvalid throttling are latched at start.
//
// Ports
//   clk, reset_n         clock, async active-low reset
//   start, abort         launch a run (IDLE only) / end a run early
//   word_count, seed     words in the run (0 = empty run), byte 0 of word 0
//   pkt_len              words per packet (0 = tlast only on final word)
//   throttle_en          gate new words with lfsr[0]
//   m_tdata/m_tvalid/m_tready/m_tlast   AXI-Stream master
//   busy, done           run in progress (RUN/DONE), one-cycle end pulse
//   words_sent           handshakes in the current or last run
module axis_pattern_source #(
  parameter int          BYTES     = 2,
  parameter logic [15:0] LFSR_INIT = 16'hACE1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic               abort,
  input  logic [31:0]        word_count,
  input  logic [7:0]         seed,
  input  logic [15:0]        pkt_len,
  input  logic               throttle_en,
  output logic [8*BYTES-1:0] m_tdata,
  output logic               m_tvalid,
  input  logic               m_tready,
  output logic               m_tlast,
  output logic               busy,
  output logic               done,
  output logic [31:0]        words_sent
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_e;
  state_e state_q, state_d;

  logic [31:0]        wc_q, wc_d;
  logic [15:0]        plen_q, plen_d;
  logic               thr_q, thr_d;
  logic [15:0]        lfsr_q, lfsr_d;
  // widx/base/pcnt describe the pending word, or the next word to present
  logic [31:0]        widx_q, widx_d;
  logic [7:0]         base_q, base_d;
  logic [15:0]        pcnt_q, pcnt_d;
  logic               abort_pend_q, abort_pend_d;
  logic [8*BYTES-1:0] tdata_q, tdata_d;
  logic               tvalid_q, tvalid_d, tlast_q, tlast_d;
  logic               busy_q, busy_d, done_q, done_d;
  logic [31:0]        ws_q, ws_d;

  logic               hs, last_word, abort_take, can_issue;
  logic [31:0]        cand_idx, eff_wc;
  logic [7:0]         cand_base;
  logic [15:0]        cand_pcnt, eff_plen;
  logic               cand_last;
  logic [8*BYTES-1:0] cand_data;

  assign hs         = tvalid_q & m_tready;
  assign last_word  = (widx_q == wc_q - 32'd1);
  // an abort waits for the pending word; it is taken once nothing is pending
  assign abort_take = (abort | abort_pend_q) & (~tvalid_q | hs);
  assign can_issue  = ~thr_q | lfsr_q[0];

  // Candidate word to present this edge: word 0 from the inputs at start,
  // the successor after a handshake, otherwise the stored next word.
  always_comb begin
    cand_idx  = widx_q;
    cand_base = base_q;
    cand_pcnt = pcnt_q;
    eff_wc    = wc_q;
    eff_plen  = plen_q;
    if (state_q == IDLE) begin
      cand_idx  = '0;
      cand_base = seed;
      cand_pcnt = '0;
      eff_wc    = word_count;
      eff_plen  = pkt_len;
    end else if (hs) begin
      cand_idx  = widx_q + 32'd1;
      cand_base = base_q + 8'(BYTES);
      cand_pcnt = (pcnt_q + 16'd1 == plen_q) ? 16'd0 : pcnt_q + 16'd1;
    end
    cand_last = ((eff_plen != 16'd0) && (cand_pcnt == eff_plen - 16'd1)) ||
                (cand_idx == eff_wc - 32'd1);
    cand_data = '0;
    for (int ii = 0; ii < BYTES; ii++) cand_data[ii*8 +: 8] = cand_base + 8'(ii);
  end

  // state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = (word_count == 32'd0) ? DONE : RUN;
      RUN:     if ((hs && last_word) || abort_take) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // outputs and datapath next values
  always_comb begin
    wc_d         = wc_q;
    plen_d       = plen_q;
    thr_d        = thr_q;
    lfsr_d       = lfsr_q;
    widx_d       = widx_q;
    base_d       = base_q;
    pcnt_d       = pcnt_q;
    abort_pend_d = abort_pend_q;
    tdata_d      = tdata_q;
    tvalid_d     = tvalid_q;
    tlast_d      = tlast_q;
    ws_d         = ws_q;
    busy_d       = (state_d != IDLE);
    done_d       = (state_d == DONE) && (state_q != DONE);
    case (state_q)
      IDLE: if (start) begin
        wc_d         = word_count;
        plen_d       = pkt_len;
        thr_d        = throttle_en;
        lfsr_d       = LFSR_INIT;
        widx_d       = '0;
        base_d       = seed;
        pcnt_d       = '0;
        abort_pend_d = 1'b0;
        ws_d         = '0;
        // unthrottled runs present word 0 on the start edge itself
        if (word_count != 32'd0 && !throttle_en) begin
          tvalid_d = 1'b1;
          tdata_d  = cand_data;
          tlast_d  = cand_last;
        end
      end
      RUN: begin
        // Fibonacci taps 16,14,13,11 (bits 0,2,3,5 in right-shift form)
        lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
        if (hs) begin
          ws_d   = ws_q + 32'd1;
          widx_d = cand_idx;
          base_d = cand_base;
          pcnt_d = cand_pcnt;
        end
        if (state_d == DONE) begin
          tvalid_d     = 1'b0;
          tlast_d      = 1'b0;
          abort_pend_d = 1'b0;
        end else if (!tvalid_q || hs) begin
          tvalid_d = can_issue;
          tlast_d  = can_issue & cand_last;
          if (can_issue) tdata_d = cand_data;
        end else if (abort) begin
          abort_pend_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wc_q         <= '0;
      plen_q       <= '0;
      thr_q        <= 1'b0;
      lfsr_q       <= LFSR_INIT;
      widx_q       <= '0;
      base_q       <= '0;
      pcnt_q       <= '0;
      abort_pend_q <= 1'b0;
      tdata_q      <= '0;
      tvalid_q     <= 1'b0;
      tlast_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      ws_q         <= '0;
    end else begin
      wc_q         <= wc_d;
      plen_q       <= plen_d;
      thr_q        <= thr_d;
      lfsr_q       <= lfsr_d;
      widx_q       <= widx_d;
      base_q       <= base_d;
      pcnt_q       <= pcnt_d;
      abort_pend_q <= abort_pend_d;
      tdata_q      <= tdata_d;
      tvalid_q     <= tvalid_d;
      tlast_q      <= tlast_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      ws_q         <= ws_d;
    end
  end

  assign m_tdata    = tdata_q;
  assign m_tvalid   = tvalid_q;
  assign m_tlast    = tlast_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign words_sent = ws_q;

endmodule

// File: tb/tb_axis_pattern_source.sv
// Bench for axis_pattern_source (BYTES=2). A table of runs is applied in a
// loop; expected words are pushed to a scoreboard at start and popped on
// each handshake. Hand sequences cover backpressure, abort and reset.
module tb_axis_pattern_source;
  localparam int B = 2;

  logic         clk = 1'b0, reset_n = 1'b0, start = 1'b0, abort = 1'b0;
  logic         throttle_en = 1'b0, m_tready = 1'b0;
  logic [31:0]  word_count = '0;
  logic [7:0]   seed = '0;
  logic [15:0]  pkt_len = '0;
  logic [8*B-1:0] m_tdata;
  logic         m_tvalid, m_tlast, busy, done;
  logic [31:0]  words_sent;

  int   n_cmp = 0, n_bad = 0;
  int   rmode = 0;           // 0: ready=1, 1: random, 2: manual_ready
  logic manual_ready = 1'b1;
  int   gaps = 0;
  logic seen_hs = 1'b0;

  typedef struct {logic [8*B-1:0] data; logic last;} word_t;
  word_t sbq[$];

  typedef struct {
    string name; logic [7:0] seed; int wc; logic [15:0] pl;
    logic thr; int rmode; logic [8*B-1:0] first;
  } vec_t;
  vec_t vt[6];

  logic prev_stall = 1'b0;
  logic [8*B-1:0] prev_d = '0;
  logic prev_l = 1'b0;

  axis_pattern_source #(.BYTES(B), .LFSR_INIT(16'hACE1)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .word_count(word_count), .seed(seed), .pkt_len(pkt_len),
    .throttle_en(throttle_en), .m_tdata(m_tdata), .m_tvalid(m_tvalid),
    .m_tready(m_tready), .m_tlast(m_tlast), .busy(busy), .done(done),
    .words_sent(words_sent));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // ready driver, changes just after the rising edge
  initial forever begin
    @(posedge clk); #1;
    case (rmode)
      0:       m_tready = 1'b1;
      1:       m_tready = 1'($urandom_range(0, 1));
      default: m_tready = manual_ready;
    endcase
  end

  // monitor: hold check while stalled, scoreboard compare on handshake
  always @(negedge clk) begin
    if (!reset_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) chk("hold", {m_tvalid, m_tlast, m_tdata}, {1'b1, prev_l, prev_d});
      if (seen_hs && busy && !m_tvalid && !done) gaps++;
      if (m_tvalid && m_tready) begin
        seen_hs = 1'b1;
        if (sbq.size() == 0) chk("sb_underflow", 64'(sbq.size()), 1);
        else begin
          word_t e;
          e = sbq.pop_front();
          chk("data", m_tdata, e.data);
          chk("tlast", m_tlast, e.last);
        end
      end
      prev_stall = m_tvalid && !m_tready;
      prev_d = m_tdata;
      prev_l = m_tlast;
    end
  end

  // called at a falling edge; start is sampled on the next rising edge
  task automatic do_start(input logic [7:0] s, input int wc, input logic [15:0] pl, input logic th);
    word_t e;
    seed = s; word_count = wc; pkt_len = pl; throttle_en = th; start = 1'b1;
    gaps = 0; seen_hs = 1'b0;
    for (int w = 0; w < wc; w++) begin
      for (int ii = 0; ii < B; ii++) e.data[ii*8 +: 8] = s + 8'(w*B + ii);
      e.last = ((pl != 16'd0) && (((w + 1) % int'(pl)) == 0)) || (w == wc - 1);
      sbq.push_back(e);
    end
    @(posedge clk); #1;
    start = 1'b0;
    // scramble the run inputs: the DUT must ignore them mid-run
    seed = 8'h99; word_count = 7; pkt_len = 16'd2; throttle_en = ~th;
  endtask

  task automatic wait_done(input int limit, inout int cyc);
    while (!done && cyc < limit) begin @(negedge clk); cyc++; end
    chk("done_seen", done, 1);
  endtask

  task automatic run_vec(input vec_t v);
    int cyc;
    rmode = v.rmode;
    do_start(v.seed, v.wc, v.pl, v.thr);
    @(negedge clk); cyc = 1;
    if (v.wc == 0) chk({v.name, "_novalid"}, m_tvalid, 0);
    else if (!v.thr) chk({v.name, "_first"}, {m_tvalid, m_tdata}, {1'b1, v.first});
    wait_done(20000, cyc);
    chk({v.name, "_busy_in_done"}, busy, 1);
    chk({v.name, "_ws"}, words_sent, 64'(v.wc));
    chk({v.name, "_sb_empty"}, 64'(sbq.size()), 0);
    if (v.rmode == 0 && !v.thr) chk({v.name, "_cycles"}, 64'(cyc), 64'(v.wc + 1));
    if (v.thr) chk({v.name, "_gaps"}, 64'(gaps > 0), 1);
    @(negedge clk);
    chk({v.name, "_done_pulse"}, done, 0);
    chk({v.name, "_busy_low"}, busy, 0);
    sbq.delete();
  endtask

  initial begin
    int cyc;
    vec_t pv;
    vt[0] = '{"basic",  8'h00,    4, 16'd0, 1'b0, 0, 16'h0100};
    vt[1] = '{"wrap",   8'hFE,    2, 16'd0, 1'b0, 0, 16'hFFFE};
    vt[2] = '{"pkt",    8'h37,   10, 16'd4, 1'b0, 0, 16'h3837};
    vt[3] = '{"thr",    8'h00, 1000, 16'd0, 1'b1, 1, 16'h0100};
    vt[4] = '{"empty",  8'h80,    0, 16'd0, 1'b0, 0, 16'h0000};
    vt[5] = '{"rndrdy", 8'h5A,   20, 16'd3, 1'b0, 1, 16'h5B5A};

    // reset state
    repeat (3) @(negedge clk);
    chk("reset_outs", {m_tvalid, m_tlast, m_tdata, busy, done, words_sent},
        {1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 32'h0});
    reset_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) run_vec(vt[i]);

    // backpressure: word 1 stalled for 5 edges
    rmode = 2; manual_ready = 1'b1;
    do_start(8'h20, 4, 16'd0, 1'b0);
    @(negedge clk); manual_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_word1", {m_tvalid, m_tdata}, {1'b1, 16'h2322});
    end
    manual_ready = 1'b1;
    cyc = 0;
    wait_done(50, cyc);
    chk("bp_ws", words_sent, 4);
    chk("bp_sb_empty", 64'(sbq.size()), 0);
    sbq.delete();
    @(negedge clk);

    // abort while word 1 is pending under ready=0
    do_start(8'h40, 50, 16'd0, 1'b0);
    @(negedge clk); manual_ready = 1'b0;
    @(negedge clk);
    chk("ab_pending", {m_tvalid, m_tdata}, {1'b1, 16'h4342});
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    @(negedge clk);
    chk("ab_still_pending", {m_tvalid, busy, done}, {1'b1, 1'b1, 1'b0});
    manual_ready = 1'b1;
    cyc = 0;
    wait_done(20, cyc);
    chk("ab_ws", words_sent, 2);
    chk("ab_valid_low", m_tvalid, 0);
    chk("ab_sb_left", 64'(sbq.size()), 48);
    sbq.delete();
    @(negedge clk);

    // reset mid-run, then a fresh run from seed 8'h10
    rmode = 0;
    do_start(8'h00, 100, 16'd0, 1'b0);
    repeat (10) @(negedge clk);
    #2 reset_n = 1'b0;
    #1 chk("rst_mid_outs", {m_tvalid, m_tlast, m_tdata, busy, done, words_sent},
           {1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 32'h0});
    sbq.delete();
    @(negedge clk); reset_n = 1'b1;
    @(negedge clk);
    pv = '{"postrst", 8'h10, 3, 16'd0, 1'b0, 0, 16'h1110};
    run_vec(pv);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/axis_pattern_source.md
# axis_pattern_source

Synthesizable AXI-Stream master that drives a deterministic incrementing-byte stream, the transmit end of the stream that the testbench monitor checks byte by byte. It sits at the DUT input in the tb_02 benches and in hardware loopback tests.
- Byte sequence is reproducible from `seed`, so any receiver can rebuild the expected data without a shared queue.
- Word count, packet framing (`tlast`) and pseudo-random `tvalid` throttling are programmable per run.

## Interface
Parameters:
- `BYTES`, 2: stream width in bytes; `m_tdata` is 8*BYTES bits. Range 1..64.
- `LFSR_INIT`, 16'hACE1: throttle LFSR load value. Must be nonzero.

Ports:
- `clk`  in  1  single clock; all logic is on its rising edge.
- `reset_n`  in  1  reset, asynchronous and active-low.
- `start`  in  1  launches a run; sampled only in IDLE.
- `abort`  in  1  ends a run early (see Operation).
- `word_count`  in  32  words in the run; 0 = run ends at once with no data.
- `seed`  in  8  value of byte lane 0 of word 0.
- `pkt_len`  in  16  words per packet; 0 = `tlast` only on the final word.
- `throttle_en`  in  1  1 = gate new words with the LFSR.
- `m_tdata`  out  8*BYTES  stream data.
- `m_tvalid`  out  1  stream valid.
- `m_tready`  in  1  stream ready from the receiver.
- `m_tlast`  out  1  end of packet.
- `busy`  out  1  high in RUN and DONE.
- `done`  out  1  one-cycle pulse at end of run.
- `words_sent`  out  32  handshakes completed in the current or last run.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE to RUN: on an edge with `start`=1.
  - RUN to DONE: on the handshake of the final word, or when an abort is taken.
  - DONE to IDLE: unconditional after one cycle.
- Start in IDLE loads `word_count`, `seed`, `pkt_len` and `throttle_en` into internal registers. Inputs that change during a run are ignored. `words_sent` clears to 0. The LFSR is loaded with LFSR_INIT.
- Word w, byte lane ii (`m_tdata[ii*8+:8]`) = (seed + w*BYTES + ii) mod 256. Bytes wrap at 8 bits. The word index is 32-bit.
- `m_tlast` = 1 when (w+1) is a multiple of `pkt_len` (if `pkt_len` != 0), or when w = word_count-1.
- A word is pending while `m_tvalid`=1 with no handshake yet.
  - Once `m_tvalid` is asserted, `m_tvalid`, `m_tdata` and `m_tlast` hold stable until the `m_tvalid`&`m_tready` edge.
  - `m_tvalid` never depends combinationally on `m_tready`.
- Throttle: the LFSR is a 16-bit Fibonacci register, taps 16,14,13,11, shifted every RUN cycle.
  - Present a new word only on an edge where lfsr[0]=1, using the value before the edge.
  - A pending word is never withdrawn.
- `abort` in RUN:
  - Taken on an edge where no word is pending or a handshake occurs.
  - Otherwise held internally until the pending word completes.
  - No further words are issued. Go to DONE.
- `word_count`=0 at start: go to DONE directly with no `m_tvalid`.
- `start` in RUN or DONE is ignored.

## Timing
- Reset values: `m_tvalid`=0, `m_tlast`=0, `m_tdata`=0, `busy`=0, `done`=0, `words_sent`=0, state IDLE, LFSR=LFSR_INIT.
- Reset asserted mid-run clears all outputs immediately, with no `done` pulse.
- All outputs are registered.
- Latency, throttle off: `m_tvalid` rises on the edge that samples `start`, so `start` at edge N gives word 0 valid after edge N.
- Full rate, `m_tready`=1, throttle off: one word per clock with no bubbles.
- `words_sent` increments on each handshake edge.
- At the final handshake edge (edge M): `m_tvalid` falls and state becomes DONE.
  - `done`=1 for the cycle after edge M.
  - `busy` falls at edge M+1.
  - A new `start` is accepted from edge M+2.
- `m_tready` low stalls with outputs frozen. The LFSR keeps shifting during the stall.

## Test plan
- Basic run. BYTES=2, seed=8'h00, word_count=4, pkt_len=0, throttle off, `m_tready`=1.
  - Required data: 16'h0100, 16'h0302, 16'h0504, 16'h0706 on 4 consecutive cycles.
  - `m_tlast` only on 16'h0706. `done` pulse one cycle later. `words_sent`=4.
- Byte wrap. seed=8'hFE, word_count=2.
  - Required data: 16'hFFFE then 16'h0100.
- Backpressure. `m_tready` held 0 for 5 cycles while word 1 is pending.
  - `m_tdata`, `m_tvalid` and `m_tlast` stable for all 5 cycles. No duplicate or lost word. Final `words_sent`=word_count.
- Packets. word_count=10, pkt_len=4.
  - `m_tlast` on words 3, 7 and 9.
- Throttle. throttle_en=1, word_count=1000, random `m_tready`.
  - Byte sequence identical to the unthrottled run. `m_tvalid` gaps present. `words_sent`=1000.
- Abort and reset.
  - `abort` while a word is pending under `m_tready`=0: that word completes when `m_tready` rises, then DONE with `words_sent` = its index + 1.
  - `reset_n` pulse mid-run: all outputs return to 0 asynchronously. A following start with seed=8'h10 begins again at byte 8'h10.
